// File: rtl/intr_ctrl_pkg.sv
// rtl/intr_ctrl_pkg.sv - shared state encoding and defaults for intr_ctrl
// Contents:
//   NUM_IRQ_DEFAULT : default number of hardware interrupt lines
//   state_e         : interrupt controller FSM state encoding
package intr_ctrl_pkg;

    localparam int NUM_IRQ_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_MEM = 2'd1,
        REQ      = 2'd2,
        SERVICE  = 2'd3
    } state_e;

endpackage

// File: rtl/intr_sync.sv
// rtl/intr_sync.sv - per-line synchronizer for external interrupt lines
// Macro INTR_SYNC_EN: defined -> two-flop synchronizer per line,
//                     undefined -> single register stage (synchronous sources).
// Ports:
//   clk      : rising-edge clock
//   resetn   : asynchronous active-low reset, clears every stage
//   async_in : raw interrupt lines
//   sync_out : sampled interrupt lines
module intr_sync
    import intr_ctrl_pkg::*;
#(
    parameter int WIDTH = NUM_IRQ_DEFAULT
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] sync_out
);

`ifdef INTR_SYNC_EN
    // First stage may go metastable; only the second stage is consumed.
    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] meta_d;
    logic [WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] sync_d;

    always_comb begin
        meta_d = async_in;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end
`else
    logic [WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] sync_d;

    always_comb begin
        sync_d = async_in;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end
`endif

    assign sync_out = sync_q;

endmodule

// File: rtl/intr_ctrl.sv
// rtl/intr_ctrl.sv - interrupt controller: line sampling, masking, priority and request FSM
// Macro INTR_SYNC_EN selects the synchronizer depth inside intr_sync (2 when
// defined, 1 otherwise); request latency from a line edge is depth + 1 cycles.
// Ports:
//   clk       : rising-edge clock
//   resetn    : asynchronous active-low reset
//   ext_intr  : level-sensitive hardware interrupt lines
//   crmd_ie   : global interrupt enable
//   ecfg_lie  : per-line enable mask
//   lsu_busy  : a load/store is outstanding
//   intr_ack  : core took the interrupt exception
//   ertn      : core committed an ertn
//   intr_req  : interrupt request to the core
//   intr_code : index of the requested line
//   estat_is  : sampled line status
//   mem_hold  : blocks issue of new memory ops
module intr_ctrl
    import intr_ctrl_pkg::*;
#(
    parameter int NUM_IRQ = NUM_IRQ_DEFAULT
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic [NUM_IRQ-1:0]         ext_intr,
    input  logic                       crmd_ie,
    input  logic [NUM_IRQ-1:0]         ecfg_lie,
    input  logic                       lsu_busy,
    input  logic                       intr_ack,
    input  logic                       ertn,
    output logic                       intr_req,
    output logic [$clog2(NUM_IRQ)-1:0] intr_code,
    output logic [NUM_IRQ-1:0]         estat_is,
    output logic                       mem_hold
);

    localparam int CW = $clog2(NUM_IRQ);

    logic [NUM_IRQ-1:0] s_irq;
    logic [NUM_IRQ-1:0] pending;
    logic               any_pending;
    logic [CW-1:0]      low_idx;

    state_e             state_q;
    state_e             state_d;
    logic [CW-1:0]      code_q;
    logic [CW-1:0]      code_d;

    intr_sync #(
        .WIDTH (NUM_IRQ)
    ) u_sync (
        .clk      (clk),
        .resetn   (resetn),
        .async_in (ext_intr),
        .sync_out (s_irq)
    );

    assign pending     = s_irq & ecfg_lie & {NUM_IRQ{crmd_ie}};
    assign any_pending = |pending;

    // Lowest-numbered line wins: scan downwards so the last hit is the lowest.
    always_comb begin
        low_idx = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (pending[i]) begin
                low_idx = CW'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        case (state_q)
            IDLE: begin
                if (any_pending) begin
                    state_d = lsu_busy ? WAIT_MEM : REQ;
                end
            end
            WAIT_MEM: begin
                if (!any_pending) begin
                    state_d = IDLE;
                end else if (!lsu_busy) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                // An ack in the same cycle as withdrawal still counts as taken.
                if (intr_ack) begin
                    state_d = SERVICE;
                end else if (!any_pending) begin
                    state_d = IDLE;
                end
            end
            SERVICE: begin
                if (ertn) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Code is captured only on entry so it stays stable for the whole request.
        if ((state_d == REQ) && (state_q != REQ)) begin
            code_d = low_idx;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            code_q  <= '0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
        end
    end

    // Outputs decode straight from flops so reset clears them asynchronously.
    assign intr_req  = (state_q == REQ);
    assign mem_hold  = (state_q == WAIT_MEM) || (state_q == REQ);
    assign intr_code = code_q;
    assign estat_is  = s_irq;

endmodule

// File: tb/tb_intr_ctrl.sv
// tb/tb_intr_ctrl.sv - self-checking bench for intr_ctrl with a behavioural reference model
module tb_intr_ctrl;

`ifdef INTR_SYNC_EN
    localparam int SYNC_DEPTH = 2;
`else
    localparam int SYNC_DEPTH = 1;
`endif

    logic       clk;
    logic       resetn;
    logic [7:0] ext_intr;
    logic       crmd_ie;
    logic [7:0] ecfg_lie;
    logic       lsu_busy;
    logic       intr_ack;
    logic       ertn;
    logic       intr_req;
    logic [2:0] intr_code;
    logic [7:0] estat_is;
    logic       mem_hold;

    int n_checks;
    int n_errors;

    // Reference model: line history plus three activity flags.
    logic [7:0] m_hist [SYNC_DEPTH];
    bit         m_req;
    bit         m_wait;
    bit         m_svc;
    int         m_code;

    intr_ctrl #(
        .NUM_IRQ (8)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .ext_intr  (ext_intr),
        .crmd_ie   (crmd_ie),
        .ecfg_lie  (ecfg_lie),
        .lsu_busy  (lsu_busy),
        .intr_ack  (intr_ack),
        .ertn      (ertn),
        .intr_req  (intr_req),
        .intr_code (intr_code),
        .estat_is  (estat_is),
        .mem_hold  (mem_hold)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < SYNC_DEPTH; k++) m_hist[k] = 8'h00;
        m_req  = 0;
        m_wait = 0;
        m_svc  = 0;
        m_code = 0;
    endtask

    // One rising edge of the model, using the inputs presented before the edge.
    task automatic model_step();
        logic [7:0] pend;
        int         low;
        pend = m_hist[SYNC_DEPTH-1] & ecfg_lie & {8{crmd_ie}};
        low  = -1;
        for (int i = 0; i < 8; i++) begin
            if (pend[i] && low < 0) low = i;
        end
        if (m_req) begin
            if (intr_ack) begin
                m_req = 0;
                m_svc = 1;
            end else if (pend == 8'h00) begin
                m_req = 0;
            end
        end else if (m_svc) begin
            if (ertn) m_svc = 0;
        end else if (pend != 8'h00) begin
            if (!lsu_busy) begin
                m_req  = 1;
                m_wait = 0;
                m_code = low;
            end else begin
                m_wait = 1;
            end
        end else begin
            m_wait = 0;
        end
        for (int k = SYNC_DEPTH - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
        m_hist[0] = ext_intr;
    endtask

    task automatic check_outputs();
        chk("estat_is", 32'(estat_is), 32'(m_hist[SYNC_DEPTH-1]));
        chk("intr_req", 32'(intr_req), 32'(m_req));
        chk("mem_hold", 32'(mem_hold), 32'(m_req | m_wait));
        if (m_req) chk("intr_code", 32'(intr_code), 32'(m_code));
    endtask

    // Called at a falling edge: present inputs, advance one cycle, compare.
    task automatic step(input logic [7:0] e, input logic ie, input logic [7:0] lie,
                        input logic b, input logic a, input logic r);
        ext_intr = e;
        crmd_ie  = ie;
        ecfg_lie = lie;
        lsu_busy = b;
        intr_ack = a;
        ertn     = r;
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic settle();
        repeat (SYNC_DEPTH + 3) step(8'h00, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic go_req(input logic [7:0] e, output int lat);
        lat = 0;
        for (int n = 0; n < 10; n++) begin
            step(e, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
            lat++;
            if (intr_req) break;
        end
        chk("reach_req", 32'(intr_req), 32'd1);
    endtask

    // Called at a falling edge; asserts reset between edges.
    task automatic async_reset();
        #2 resetn = 1'b0;
        model_reset();
        #1;
        chk("rst_intr_req", 32'(intr_req), 32'd0);
        chk("rst_mem_hold", 32'(mem_hold), 32'd0);
        chk("rst_intr_code", 32'(intr_code), 32'd0);
        chk("rst_estat_is", 32'(estat_is), 32'd0);
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
    endtask

    initial begin
        int lat;
        n_checks = 0;
        n_errors = 0;
        resetn   = 1'b0;
        ext_intr = 8'hFF;
        crmd_ie  = 1'b1;
        ecfg_lie = 8'hFF;
        lsu_busy = 1'b0;
        intr_ack = 1'b0;
        ertn     = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        chk("reset_intr_req", 32'(intr_req), 32'd0);
        chk("reset_estat_is", 32'(estat_is), 32'd0);
        chk("reset_mem_hold", 32'(mem_hold), 32'd0);
        chk("reset_intr_code", 32'(intr_code), 32'd0);
        ext_intr = 8'h00;
        resetn   = 1'b1;
        settle();

        // Basic request, latency, ack and ertn.
        go_req(8'h01, lat);
        chk("latency", 32'(lat), 32'(SYNC_DEPTH + 1));
        chk("basic_code", 32'(intr_code), 32'd0);
        step(8'h01, 1'b1, 8'hFF, 1'b0, 1'b1, 1'b0);
        chk("svc_no_req", 32'(intr_req), 32'd0);
        repeat (SYNC_DEPTH + 2) step(8'h00, 1'b1, 8'hFF, 1'b0, 1'b1, 1'b0);
        step(8'h00, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b1);
        settle();

        // Interrupt during a load.
        repeat (SYNC_DEPTH + 3) step(8'h04, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0);
        chk("wait_hold", 32'(mem_hold), 32'd1);
        chk("wait_noreq", 32'(intr_req), 32'd0);
        step(8'h04, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
        chk("wait_release_req", 32'(intr_req), 32'd1);
        chk("wait_release_code", 32'(intr_code), 32'd2);
        step(8'h04, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0);
        chk("busy_keeps_req", 32'(intr_req), 32'd1);
        settle();

        // Priority and code stability.
        go_req(8'h90, lat);
        chk("prio_code", 32'(intr_code), 32'd4);
        repeat (SYNC_DEPTH + 1) step(8'h10, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
        chk("prio_code_hold", 32'(intr_code), 32'd4);
        settle();

        // Masking by line mask and by global enable.
        for (int n = 0; n < 6; n++) step(8'($urandom), 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("mask_lie_noreq", 32'(intr_req), 32'd0);
        for (int n = 0; n < 6; n++) step(8'($urandom), 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0);
        chk("mask_ie_noreq", 32'(intr_req), 32'd0);
        settle();

        // Withdrawal without ack, then withdrawal coinciding with ack.
        go_req(8'h01, lat);
        repeat (SYNC_DEPTH + 1) step(8'h00, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
        chk("withdraw_idle", 32'(intr_req), 32'd0);
        settle();
        go_req(8'h01, lat);
        repeat (SYNC_DEPTH) step(8'h00, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
        step(8'h00, 1'b1, 8'hFF, 1'b0, 1'b1, 1'b0);
        repeat (SYNC_DEPTH + 2) step(8'h01, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
        chk("withdraw_ack_svc", 32'(intr_req), 32'd0);
        settle();

        // Reset in the middle of a request.
        go_req(8'h08, lat);
        async_reset();
        settle();

        // Randomized traffic with one reset along the way.
        for (int n = 0; n < 400; n++) begin
            logic [7:0] e;
            e = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            step(e, ($urandom_range(0, 7) != 0), 8'($urandom),
                 ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 3) == 0));
            if (n == 200) async_reset();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/intr_ctrl.md
INTR_CTRL -- requirements
Module: intr_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; the ports are named clk and resetn.
REQ-002 Parameter NUM_IRQ, default 8, SHALL set the number of hardware interrupt lines.
REQ-003 Port clk, input, 1: rising-edge clock.
REQ-004 Port resetn, input, 1: asynchronous active-low reset.
REQ-005 Port ext_intr, input, NUM_IRQ: level-sensitive hardware interrupt lines, asynchronous to clk.
REQ-006 Port crmd_ie, input, 1: global interrupt enable from the CSR file.
REQ-007 Port ecfg_lie, input, NUM_IRQ: per-line enable mask from the CSR file.
REQ-008 Port lsu_busy, input, 1: a load or store is outstanding on the AXI port.
REQ-009 Port intr_ack, input, 1: the core has taken the interrupt exception at writeback.
REQ-010 Port ertn, input, 1: the core has committed an ertn.
REQ-011 Port intr_req, output, 1: interrupt request to the core.
REQ-012 Port intr_code, output, log2(NUM_IRQ): index of the requested line.
REQ-013 Port estat_is, output, NUM_IRQ: sampled line status for ESTAT.IS.
REQ-014 Port mem_hold, output, 1: blocks issue of new memory ops.

Function
REQ-015 s_irq SHALL be the sampled ext_intr; estat_is SHALL equal s_irq.
REQ-016 pending SHALL equal s_irq AND ecfg_lie AND crmd_ie, replicated across all lines.
REQ-017 The FSM SHALL use states IDLE, WAIT_MEM, REQ and SERVICE.
REQ-018 IDLE: when any pending bit is set, the FSM SHALL go to REQ if lsu_busy=0, else to WAIT_MEM.
REQ-019 WAIT_MEM: if pending is all zero, the FSM SHALL return to IDLE; else if lsu_busy=0, it SHALL go to REQ.
REQ-020 On entry to REQ, intr_code SHALL latch the index of the lowest set pending bit and stay constant while in REQ.
REQ-021 In REQ, intr_req SHALL be 1; on intr_ack=1 the FSM SHALL go to SERVICE.
REQ-022 In REQ with intr_ack=0 and pending all zero, the FSM SHALL drop to IDLE; intr_ack SHALL take priority when both occur in the same cycle.
REQ-023 SERVICE SHALL issue no new request; ertn=1 SHALL return the FSM to IDLE.
REQ-024 intr_ack outside REQ and ertn outside SERVICE SHALL be ignored.
REQ-025 mem_hold SHALL be 1 in WAIT_MEM and REQ; lsu_busy rising while in REQ SHALL NOT withdraw intr_req.
REQ-026 Latency from an ext_intr edge to intr_req=1, with lsu_busy=0, SHALL be sync depth + 1 cycles.

Reset
REQ-027 While resetn=0, the FSM SHALL be in IDLE, and s_irq, synchronizer flops, intr_req, intr_code, estat_is and mem_hold SHALL all be 0.
REQ-028 Reset asserted mid-request SHALL drop intr_req asynchronously.
REQ-029 After reset deassertion, pending SHALL be re-evaluated starting from the next edge.

Configuration
REQ-030 With INTR_SYNC_EN defined, ext_intr SHALL pass through a 2-flop synchronizer per line, giving a sync depth of 2 and a latency of 3 cycles.
REQ-031 Without INTR_SYNC_EN, ext_intr SHALL be registered once, giving a sync depth of 1 and a latency of 2 cycles; this is for on-chip synchronous sources only.

Structure
REQ-032 The shared package SHALL hold the state encoding constants (IDLE=0, WAIT_MEM=1, REQ=2, SERVICE=3) and the default NUM_IRQ.
REQ-033 Sub-module intr_sync SHALL implement the per-line synchronizer, with depth selected by INTR_SYNC_EN; the FSM and priority encoder SHALL stay in intr_ctrl.

Verification
REQ-034 Basic request: ext_intr=8'h01, crmd_ie=1, ecfg_lie=8'hFF, lsu_busy=0 -> intr_req=1 after 3 cycles with INTR_SYNC_EN, intr_code=0; intr_ack -> SERVICE; ertn -> IDLE.
REQ-035 Interrupt during a load: lsu_busy=1 when ext_intr=8'h04 arrives -> FSM in WAIT_MEM, mem_hold=1, intr_req=0; lsu_busy falls -> intr_req=1 on the next cycle, intr_code=2.
REQ-036 Priority: ext_intr=8'h90 -> intr_code=4; line 7 deasserted while in REQ -> intr_code unchanged.
REQ-037 Masking: ecfg_lie=8'h00 or crmd_ie=0 -> estat_is tracks ext_intr but intr_req stays 0.
REQ-038 Withdrawal: ext_intr falls in REQ without ack -> IDLE and intr_req=0; falls in the same cycle as intr_ack -> SERVICE.
REQ-039 Reset mid-REQ: resetn=0 -> intr_req=0 immediately and all outputs 0.
